// File: rtl/mul_pkg.sv
// Shared types for the FP multiplier normalise/round stage: widths, rounding modes,
// per-stage payload structs and the round-increment rule.
package mul_pkg;

   localparam int EXPO_W = 8;
   localparam int MANT_W = 23;
   localparam int EXPO_I = EXPO_W + 2;
   localparam int PROD_W = 2 * MANT_W + 2;

   // Largest finite biased exponent is EXPO_MAX-1; EXPO_MAX itself is inf/NaN.
   localparam logic [EXPO_I-1:0] EXPO_MAX  = EXPO_I'((1 << EXPO_W) - 1);
   localparam logic [EXPO_I-1:0] EXPO_ZERO = '0;

   typedef enum logic [1:0] {
      RTZ = 2'b00,
      RDN = 2'b01,
      RUP = 2'b10,
      RNE = 2'b11
   } rnd_mode_e;

   typedef struct packed {
      logic              sign;
      logic [EXPO_I-1:0] expo;
      logic [MANT_W-1:0] frac;
      logic              g;
      logic              s;
      logic              isZero;
      logic              isInfNan;
      logic              signNan;
      logic [MANT_W-1:0] mantNan;
      rnd_mode_e         rnd;
   } stage_a_t;

   typedef struct packed {
      logic              isInfNan;
      logic              signNan;
      logic [MANT_W-1:0] mantNan;
      logic              overflow;
      rnd_mode_e         rnd;
      logic              sign;
      logic [EXPO_W-1:0] expo;
      logic [MANT_W-1:0] mant;
      logic              underflow;
   } stage_b_t;

   function automatic logic roundInc(input rnd_mode_e rnd, input logic lsb,
                                     input logic g, input logic s, input logic sign);
      logic inc;
      inc = 1'b0;
      case (rnd)
         RTZ:     inc = 1'b0;
         RDN:     inc = (g | s) & sign;
         RUP:     inc = (g | s) & ~sign;
         RNE:     inc = g & (s | lsb);
         default: inc = 1'b0;
      endcase
      return inc;
   endfunction

endpackage

// File: rtl/mul_round_stage_if.sv
// Handshake and payload bundle between the partial-product stage, this normalise/round
// stage and the result mux. The stage itself uses the slave view.
interface mul_round_stage_if;
   import mul_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic [EXPO_I-1:0] in_expo;
   logic [PROD_W-1:0] in_prod;
   logic              in_is_zero;
   logic              in_is_inf_nan;
   logic              in_sign_nan;
   logic [MANT_W-1:0] in_mant_nan;
   logic [1:0]        in_rnd;

   logic              out_valid;
   logic              out_ready;
   logic              is_inf_nan;
   logic              sign_nan;
   logic [MANT_W-1:0] mant_4;
   logic              overflow;
   logic [1:0]        rnd;
   logic              sign_1;
   logic [EXPO_W-1:0] expo_3;
   logic [MANT_W-1:0] mant_3;
   logic              underflow;

   modport master (
      output in_valid, in_sign, in_expo, in_prod, in_is_zero, in_is_inf_nan,
             in_sign_nan, in_mant_nan, in_rnd, out_ready,
      input  in_ready, out_valid, is_inf_nan, sign_nan, mant_4, overflow, rnd,
             sign_1, expo_3, mant_3, underflow
   );

   modport slave (
      input  in_valid, in_sign, in_expo, in_prod, in_is_zero, in_is_inf_nan,
             in_sign_nan, in_mant_nan, in_rnd, out_ready,
      output in_ready, out_valid, is_inf_nan, sign_nan, mant_4, overflow, rnd,
             sign_1, expo_3, mant_3, underflow
   );

endinterface

// File: rtl/mul_round_inc.sv
// Applies the rounding increment to a fraction; shared with the add pipe's round stage.
module mul_round_inc
   import mul_pkg::*;
(
   input  logic [MANT_W-1:0] frac_i,
   input  logic              g_i,
   input  logic              s_i,
   input  logic              sign_i,
   input  rnd_mode_e         rnd_i,
   output logic [MANT_W-1:0] frac_o,
   output logic              carry_o
);

   logic inc;

   assign inc               = roundInc(rnd_i, frac_i[0], g_i, s_i, sign_i);
   assign {carry_o, frac_o} = {1'b0, frac_i} + {{MANT_W{1'b0}}, inc};

endmodule

// File: rtl/mul_round_stage.sv
// Normalise (stage A) and round/range-check (stage B) of the FP multiplier, as a
// two-deep valid/ready pipeline whose stage-B registers drive the result mux directly.
module mul_round_stage
   import mul_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   mul_round_stage_if.slave   bus
);

   logic     validA_q, validA_d;
   logic     validB_q, validB_d;
   stage_a_t stageA_q, stageA_d;
   stage_b_t stageB_q, stageB_d;

   logic              loadB;
   logic              inFire;
   logic [MANT_W-1:0] fracR;
   logic              carry;
   logic [EXPO_I-1:0] expoR;
   logic              special;
   logic              expoHigh;
   logic              expoLow;

   assign loadB        = !validB_q || bus.out_ready;
   assign bus.in_ready = !validA_q || loadB;
   assign inFire       = bus.in_valid && bus.in_ready;

   // A product in [2,4) is shifted right once; the dropped bit lands in the sticky.
   always_comb begin
      stageA_d = stageA_q;
      validA_d = validA_q;
      if (inFire) begin
         validA_d          = 1'b1;
         stageA_d.sign     = bus.in_sign;
         stageA_d.isZero   = bus.in_is_zero;
         stageA_d.isInfNan = bus.in_is_inf_nan;
         stageA_d.signNan  = bus.in_sign_nan;
         stageA_d.mantNan  = bus.in_mant_nan;
         stageA_d.rnd      = rnd_mode_e'(bus.in_rnd);
         if (bus.in_prod[PROD_W-1]) begin
            stageA_d.expo = bus.in_expo + EXPO_I'(1);
            stageA_d.frac = bus.in_prod[2*MANT_W -: MANT_W];
            stageA_d.g    = bus.in_prod[MANT_W];
            stageA_d.s    = |bus.in_prod[MANT_W-1:0];
         end else begin
            stageA_d.expo = bus.in_expo;
            stageA_d.frac = bus.in_prod[2*MANT_W-1 -: MANT_W];
            stageA_d.g    = bus.in_prod[MANT_W-1];
            stageA_d.s    = |bus.in_prod[MANT_W-2:0];
         end
      end else if (loadB) begin
         validA_d = 1'b0;
      end
   end

   mul_round_inc u_round (
      .frac_i  (stageA_q.frac),
      .g_i     (stageA_q.g),
      .s_i     (stageA_q.s),
      .sign_i  (stageA_q.sign),
      .rnd_i   (stageA_q.rnd),
      .frac_o  (fracR),
      .carry_o (carry)
   );

   assign expoR    = stageA_q.expo + EXPO_I'(carry);
   assign special  = stageA_q.isInfNan || stageA_q.isZero;
   assign expoHigh = $signed(expoR) >= $signed(EXPO_MAX);
   assign expoLow  = $signed(expoR) <= $signed(EXPO_ZERO);

   // B only captures real beats so idle cycles never disturb the held outputs.
   always_comb begin
      stageB_d = stageB_q;
      validB_d = validB_q;
      if (loadB) begin
         validB_d = validA_q;
         if (validA_q) begin
            stageB_d.isInfNan  = stageA_q.isInfNan;
            stageB_d.signNan   = stageA_q.signNan;
            stageB_d.mantNan   = stageA_q.mantNan;
            stageB_d.rnd       = stageA_q.rnd;
            stageB_d.sign      = stageA_q.sign;
            stageB_d.overflow  = expoHigh && !special;
            stageB_d.underflow = expoLow && !special;
            if (special || expoLow) begin
               stageB_d.expo = '0;
               stageB_d.mant = '0;
            end else begin
               stageB_d.expo = expoR[EXPO_W-1:0];
               stageB_d.mant = fracR;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         validA_q <= 1'b0;
         validB_q <= 1'b0;
         stageA_q <= '0;
         stageB_q <= '0;
      end else begin
         validA_q <= validA_d;
         validB_q <= validB_d;
         stageA_q <= stageA_d;
         stageB_q <= stageB_d;
      end
   end

   assign bus.out_valid  = validB_q;
   assign bus.is_inf_nan = stageB_q.isInfNan;
   assign bus.sign_nan   = stageB_q.signNan;
   assign bus.mant_4     = stageB_q.mantNan;
   assign bus.overflow   = stageB_q.overflow;
   assign bus.rnd        = stageB_q.rnd;
   assign bus.sign_1     = stageB_q.sign;
   assign bus.expo_3     = stageB_q.expo;
   assign bus.mant_3     = stageB_q.mant;
   assign bus.underflow  = stageB_q.underflow;

endmodule

// File: tb/tb_mul_round_stage.sv
// Bench for mul_round_stage: directed cases plus a random stream, scored against an
// arithmetic (quotient/remainder) model of normalise-and-round.
module tb_mul_round_stage;
   import mul_pkg::*;

   typedef struct {
      bit        sign;
      bit [9:0]  expo;
      bit [47:0] prod;
      bit        isZero;
      bit        isInfNan;
      bit        signNan;
      bit [22:0] mantNan;
      bit [1:0]  rnd;
   } beat_t;

   typedef struct {
      bit        isInfNan;
      bit        signNan;
      bit [22:0] mantNan;
      bit        ovf;
      bit [1:0]  rnd;
      bit        sign;
      bit [7:0]  expo;
      bit [22:0] mant;
      bit        unf;
      bit        chkVal;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mul_round_stage_if bus ();

   mul_round_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int    errors = 0;
   int    checks = 0;
   exp_t  expQ[$];
   beat_t curBeat;
   bit    haveBeat = 1'b0;
   beat_t bp[4];

   // Reference: value = prod / 2^46; keep 24 significant bits as a quotient, round on the remainder.
   function automatic exp_t modelBeat(input beat_t b);
      exp_t            e;
      longint unsigned p, q, rem, half;
      int              sh, ex;
      bit              inc;
      e = '{default: 0};
      e.rnd      = b.rnd;
      e.sign     = b.sign;
      e.isInfNan = b.isInfNan;
      e.signNan  = b.signNan;
      e.mantNan  = b.mantNan;
      if (b.isInfNan) return e;
      if (b.isZero) begin
         e.chkVal = 1'b1;
         return e;
      end
      p    = {16'b0, b.prod};
      sh   = p[47] ? 24 : 23;
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      case (b.rnd)
         2'd0:    inc = 1'b0;
         2'd1:    inc = (rem != 0) && b.sign;
         2'd2:    inc = (rem != 0) && !b.sign;
         default: inc = (rem > half) || ((rem == half) && q[0]);
      endcase
      q  = q + {63'b0, inc};
      ex = int'($signed(b.expo)) + ((sh == 24) ? 1 : 0);
      if (q == (64'd1 << 24)) begin
         q  = q >> 1;
         ex = ex + 1;
      end
      e.ovf    = ex >= 255;
      e.unf    = ex <= 0;
      e.chkVal = !e.ovf;
      if (!e.unf && !e.ovf) begin
         e.expo = ex[7:0];
         e.mant = q[22:0];
      end
      return e;
   endfunction

   task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic failNow(input string tag);
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=timeout expected=completion", tag);
   endtask

   task automatic checkOutput(input exp_t e);
      checkEq("sign_1", 64'(bus.sign_1), 64'(e.sign));
      checkEq("rnd", 64'(bus.rnd), 64'(e.rnd));
      checkEq("is_inf_nan", 64'(bus.is_inf_nan), 64'(e.isInfNan));
      checkEq("sign_nan", 64'(bus.sign_nan), 64'(e.signNan));
      checkEq("mant_4", 64'(bus.mant_4), 64'(e.mantNan));
      checkEq("overflow", 64'(bus.overflow), 64'(e.ovf));
      checkEq("underflow", 64'(bus.underflow), 64'(e.unf));
      if (e.chkVal) begin
         checkEq("expo_3", 64'(bus.expo_3), 64'(e.expo));
         checkEq("mant_3", 64'(bus.mant_3), 64'(e.mant));
      end
   endtask

   task automatic checkCleared(input string tag);
      checkEq({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
      checkEq({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
      checkEq({tag, "_expo_3"}, 64'(bus.expo_3), 64'(0));
      checkEq({tag, "_mant_3"}, 64'(bus.mant_3), 64'(0));
      checkEq({tag, "_mant_4"}, 64'(bus.mant_4), 64'(0));
      checkEq({tag, "_flags"}, 64'({bus.overflow, bus.underflow, bus.is_inf_nan,
                                    bus.sign_nan, bus.sign_1, bus.rnd}), 64'(0));
   endtask

   // One clock: drive at posedge+1, score handshakes at negedge, return at posedge+1.
   task automatic applyStimulus(input bit outRdy);
      bit inFire, outFire;
      bus.in_valid      = haveBeat;
      bus.in_sign       = curBeat.sign;
      bus.in_expo       = curBeat.expo;
      bus.in_prod       = curBeat.prod;
      bus.in_is_zero    = curBeat.isZero;
      bus.in_is_inf_nan = curBeat.isInfNan;
      bus.in_sign_nan   = curBeat.signNan;
      bus.in_mant_nan   = curBeat.mantNan;
      bus.in_rnd        = curBeat.rnd;
      bus.out_ready     = outRdy;
      @(negedge clk);
      inFire  = bus.in_valid && bus.in_ready;
      outFire = bus.out_valid && bus.out_ready;
      if (outFire) begin
         if (expQ.size() == 0) checkEq("unexpected_beat", 64'(1), 64'(0));
         else checkOutput(expQ.pop_front());
      end
      if (inFire) begin
         expQ.push_back(modelBeat(curBeat));
         haveBeat = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic sendBeat(input beat_t b, input bit outRdy);
      curBeat  = b;
      haveBeat = 1'b1;
      for (int i = 0; i < 20 && haveBeat; i++) applyStimulus(outRdy);
      if (haveBeat) begin
         failNow("send_timeout");
         haveBeat = 1'b0;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 50 && expQ.size() > 0; i++) applyStimulus(1'b1);
      if (expQ.size() > 0) begin
         failNow("drain_timeout");
         expQ.delete();
      end
   endtask

   function automatic beat_t mkBeat(input bit [9:0] expo, input bit [47:0] prod,
                                    input bit [1:0] rnd, input bit sign);
      beat_t b;
      b = '{default: 0};
      b.expo = expo;
      b.prod = prod;
      b.rnd  = rnd;
      b.sign = sign;
      return b;
   endfunction

   function automatic beat_t randBeat();
      beat_t b;
      int    sel, ev;
      sel = int'($urandom_range(0, 9));
      if (sel < 6)       ev = int'($urandom_range(1, 253));
      else if (sel < 8)  ev = int'($urandom_range(252, 256));
      else               ev = int'($urandom_range(0, 4)) - 3;
      b.sign     = 1'($urandom);
      b.expo     = 10'(ev);
      b.prod     = {16'($urandom), 32'($urandom)};
      if (b.prod[47:46] == 2'b00) b.prod[46] = 1'b1;
      b.isZero   = ($urandom_range(0, 15) == 0);
      b.isInfNan = ($urandom_range(0, 15) == 0);
      b.signNan  = 1'($urandom);
      b.mantNan  = 23'($urandom);
      b.rnd      = 2'($urandom);
      return b;
   endfunction

   initial begin
      beat_t b;
      int    idx;
      curBeat = '{default: 0};
      rst = 1'b1;
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      checkCleared("reset");
      rst = 1'b0;

      $display("[TB] latency and unity product");
      sendBeat(mkBeat(10'd127, 48'd1 << 46, 2'b11, 1'b0), 1'b1);
      checkEq("lat_cycle1_out_valid", 64'(bus.out_valid), 64'(0));
      applyStimulus(1'b1);
      checkEq("lat_cycle2_out_valid", 64'(bus.out_valid), 64'(1));
      drain();

      $display("[TB] rounding carry, overflow, rounding direction");
      sendBeat(mkBeat(10'd100, 48'hFFFF_FFFF_FFFF, 2'b11, 1'b0), 1'b1);
      sendBeat(mkBeat(10'd100, 48'hFFFF_FFFF_FFFF, 2'b00, 1'b0), 1'b1);
      for (int r = 0; r < 4; r++) sendBeat(mkBeat(10'd254, 48'd3 << 46, 2'(r), 1'b0), 1'b1);
      for (int r = 1; r < 4; r++)
         sendBeat(mkBeat(10'd60, (48'd1 << 46) | (48'd1 << 22), 2'(r), 1'b1), 1'b1);
      drain();

      $display("[TB] inf/NaN priority and underflow");
      b = mkBeat(10'd300, 48'd1 << 46, 2'b11, 1'b0);
      b.isInfNan = 1'b1;
      b.signNan  = 1'b1;
      b.mantNan  = 23'h400000;
      sendBeat(b, 1'b1);
      sendBeat(mkBeat(10'h3FB, 48'd1 << 46, 2'b11, 1'b1), 1'b1);
      b = mkBeat(10'd200, 48'd3 << 46, 2'b10, 1'b1);
      b.isZero = 1'b1;
      sendBeat(b, 1'b1);
      drain();

      $display("[TB] backpressure");
      for (int i = 0; i < 4; i++) bp[i] = mkBeat(10'(20 + i), (48'd1 << 46) | 48'(i * 977), 2'b11, 1'b0);
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         if (idx < 4 && !haveBeat) begin
            curBeat  = bp[idx];
            haveBeat = 1'b1;
         end
         applyStimulus(1'b0);
         if (!haveBeat) idx++;
      end
      checkEq("bp_accepted", 64'(idx), 64'(2));
      checkEq("bp_in_ready", 64'(bus.in_ready), 64'(0));
      checkEq("bp_out_valid", 64'(bus.out_valid), 64'(1));
      checkEq("bp_held_expo", 64'(bus.expo_3), 64'(20));
      for (int c = 0; c < 20 && (idx < 4 || haveBeat); c++) begin
         if (idx < 4 && !haveBeat) begin
            curBeat  = bp[idx];
            haveBeat = 1'b1;
         end
         applyStimulus(1'b1);
         if (!haveBeat) idx++;
      end
      drain();

      $display("[TB] random stream");
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 4) == 0) applyStimulus(1'($urandom_range(0, 3) != 0));
         curBeat  = randBeat();
         haveBeat = 1'b1;
         for (int i = 0; i < 30 && haveBeat; i++) applyStimulus(1'($urandom_range(0, 3) != 0));
         if (haveBeat) begin
            failNow("random_send_timeout");
            haveBeat = 1'b0;
         end
      end
      drain();

      $display("[TB] reset with beats in flight");
      sendBeat(mkBeat(10'd90, 48'd3 << 46, 2'b10, 1'b1), 1'b0);
      sendBeat(mkBeat(10'd91, 48'd1 << 46, 2'b01, 1'b1), 1'b0);
      rst = 1'b1;
      applyStimulus(1'b0);
      checkCleared("midreset");
      expQ.delete();
      rst = 1'b0;
      sendBeat(mkBeat(10'd5, 48'd1 << 46, 2'b11, 1'b0), 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mul_round_stage.md
Name: mul_round_stage

Overview:
- Normalise/round stage of the 3-stage FP multiplier; sits directly upstream of the result mux and drives its inputs.
- Takes the raw significand product, the exponent sum and the special-case flags from the partial-product stage.
- Normalises, rounds per the rnd mode and flags overflow/underflow, through a 2-deep valid/ready pipeline that can stall.

Parameters:
EXPO_W, 8, exponent field width
MANT_W, 23, stored mantissa width (hidden bit excluded)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
in_sign  in  1  product sign (sign_a ^ sign_b)
in_expo  in  EXPO_W+2  signed two's-complement biased exponent sum (ea+eb-bias)
in_prod  in  2*MANT_W+2  significand product, value in [1,4), binary point below bit 2*MANT_W
in_is_zero  in  1  either operand zero (and no NaN/inf)
in_is_inf_nan  in  1  result is inf or NaN
in_sign_nan  in  1  sign for the inf/NaN result
in_mant_nan  in  MANT_W  mantissa for the inf/NaN result (0 = inf, quiet-NaN payload otherwise)
in_rnd  in  2  rounding mode: 00 RTZ, 01 RDN, 10 RUP, 11 RNE
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts beat
is_inf_nan, sign_nan, mant_4  out  1/1/MANT_W  registered copies of in_is_inf_nan/in_sign_nan/in_mant_nan
overflow  out  1  rounded exponent >= 2^EXPO_W-1
rnd  out  2  registered copy of in_rnd
sign_1  out  1  result sign
expo_3  out  EXPO_W  rounded biased exponent
mant_3  out  MANT_W  rounded mantissa
underflow  out  1  result flushed to zero

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset clears both stage valid bits and every output register; all outputs read 0 after reset.
- Pipeline: stage A (normalise) feeds stage B (round). Latency is 2 cycles with no stalls. Throughput is 1 beat/cycle.
- Handshake: a beat transfers when valid && ready.
  - in_ready = !vA || (!vB || out_ready), combinational.
  - B loads from A when !vB || out_ready.
  - out_valid = vB. Outputs stay stable while out_valid && !out_ready.
  - No beat is dropped or duplicated.
- Stage A:
  - If in_prod[2*MANT_W+1]=1: shift right 1 and expo+1.
  - Keep MANT_W fraction bits, guard bit g, and sticky s = OR of all lower bits. The bit shifted out joins the sticky.
  - Register sign, expo (EXPO_W+2), fraction, g, s, flags and rnd.
- Stage B, round increment:
  - RTZ: 0.
  - RNE: g & (s | lsb).
  - RUP: (g|s) & !sign.
  - RDN: (g|s) & sign.
- Stage B, carry and range checks:
  - Fraction carry-out: fraction becomes 0, expo+1.
  - overflow = (expo >= 2^EXPO_W-1) && !is_inf_nan && !is_zero.
  - On overflow, expo_3/mant_3 are don't-care (the downstream mux substitutes).
  - underflow: expo <= 0 after rounding, no special flags. Force expo_3=0, mant_3=0, keep sign (flush-to-zero; denormals not produced).
- Zero input: expo_3=0, mant_3=0, overflow=0, underflow=0, sign_1=in_sign.
- is_inf_nan input has priority over all; overflow and underflow are forced to 0.
- Simultaneous in and out transfer while both stages are full: A→B and in→A happen in the same cycle.
- rst asserted mid-stream discards all in-flight beats on the next edge; in_ready reads 1 during reset.

Decomposition:
- Shared package mul_pkg holds:
  - rnd_mode_e enum (RTZ=2'b00, RDN=2'b01, RUP=2'b10, RNE=2'b11);
  - struct types for the stage-A and stage-B payloads, parameterised by EXPO_W/MANT_W via localparams;
  - the round-increment function.
- One natural sub-module: mul_round_inc (combinational). It takes fraction, g, s, sign and rnd, and returns the rounded fraction and carry. This lets it be reused by the add pipe.

Test Plan:
1. All tests use defaults EXPO_W=8, MANT_W=23. in_prod=1<<46, in_expo=127, RNE → after 2 cycles: out_valid=1, expo_3=127, mant_3=0, overflow=0.
2. in_prod=48'hFFFFFFFFFFFF, in_expo=100, RNE → normalise gives expo 101. Rounding carries, so expo_3=102, mant_3=0. Same input with RTZ → expo_3=101, mant_3=23'h7FFFFF.
3. in_expo=254, in_prod=3<<46 → overflow=1 for every rnd mode.
4. Rounding direction: guard=1, sticky=0, lsb=0, sign=1.
   - RDN → mant_3 lsb=1.
   - RUP → unchanged.
   - RNE → unchanged (tie to even).
5. in_is_inf_nan=1, in_mant_nan=23'h400000, in_expo=300 → is_inf_nan=1, mant_4=23'h400000, overflow=0. in_expo=-5 with a finite input → underflow=1, expo_3=0, mant_3=0.
6. Backpressure and reset:
   - Send 4 back-to-back beats with out_ready=0 for 5 cycles → in_ready falls after 2 accepted beats, out_valid stays held.
   - Release out_ready → beats emerge in order, none lost.
   - Assert rst with 2 beats in flight → next cycle out_valid=0 and all outputs 0.
